// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, oversampled by CLKS_PER_BIT system clocks per bit.
//
// Parameters:
//   CLKS_PER_BIT   system clocks per serial bit (4..128)
// Ports:
//   i_Clock        system clock, rising edge
//   i_Reset        synchronous active-high reset
//   i_Rx_Serial    asynchronous serial input, idle high
//   o_Rx_DV        one-cycle pulse, o_Rx_Byte holds a newly received byte
//   o_Rx_Byte      last accepted data byte
//   o_Rx_Active    high while a frame is in progress
//   o_Rx_Frame_Err one-cycle pulse when the stop bit is sampled low
//                  (present only when UART_RX_FRAME_ERR_EN is defined)
//
// Build option:
//   UART_RX_FRAME_ERR_EN  enables stop-bit checking and o_Rx_Frame_Err.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       o_Rx_Frame_Err
`endif
);

  localparam int unsigned CNT_W  = 7;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTE_W - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [BYTE_W-1:0]   byte_d;
  logic                dv_d;
  logic                active_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic                ferr_d;
`endif

  logic                rx_meta;
  logic                rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      data_q         <= '0;
      o_Rx_Byte      <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Active    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      o_Rx_Frame_Err <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      data_q         <= data_d;
      o_Rx_Byte      <= byte_d;
      o_Rx_DV        <= dv_d;
      o_Rx_Active    <= active_d;
`ifdef UART_RX_FRAME_ERR_EN
      o_Rx_Frame_Err <= ferr_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    byte_d   = o_Rx_Byte;
    active_d = o_Rx_Active;
    dv_d     = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d  = START;
          active_d = 1'b1;
        end
      end

      // Re-check the line at mid start bit to reject short glitches.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Sample each data bit one full bit period after the previous sample point.
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = CLEANUP;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s) begin
            dv_d   = 1'b1;
            byte_d = data_q;
          end else begin
            ferr_d = 1'b1;
          end
`else
          dv_d   = 1'b1;
          byte_d = data_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CLEANUP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning system clocks per serial bit; legal range 4..128.
REQ-002 SHALL have port i_Clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte is valid.
REQ-006 SHALL have port o_Rx_Byte  output  8  last received data byte.
REQ-007 SHALL have port o_Rx_Active  output  1  high while a frame is being received.
REQ-008 SHALL have port o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low. Present only with UART_RX_FRAME_ERR_EN.

Function
REQ-009 SHALL pass i_Rx_Serial through a two-flop synchronizer; all other logic SHALL use only the synchronized bit (rx_s).
REQ-010 SHALL implement states IDLE, START, DATA, STOP, CLEANUP; unused encodings SHALL return to IDLE next cycle.
REQ-011 IDLE: clock counter and bit index held at 0; rx_s==0 -> START, o_Rx_Active set to 1.
REQ-012 START: counter increments each cycle; at count==(CLKS_PER_BIT-1)/2 (integer division), rx_s==0 -> counter cleared, DATA; rx_s==1 -> IDLE, o_Rx_Active cleared (glitch rejection).
REQ-013 DATA: counter counts 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 rx_s SHALL be written to byte bit[index], counter cleared; index 0..6 -> increment; index 7 -> index 0, STOP.
REQ-014 Data SHALL be received LSB first; sample points SHALL be exactly CLKS_PER_BIT cycles apart, the first lying CLKS_PER_BIT cycles after the START validation cycle.
REQ-015 STOP: after CLKS_PER_BIT-1 counts, rx_s sampled; o_Rx_DV pulses high the following cycle, o_Rx_Active cleared, state -> CLEANUP.
REQ-016 CLEANUP: lasts exactly one cycle, o_Rx_DV low, state -> IDLE.
REQ-017 o_Rx_DV SHALL be high for exactly one cycle per accepted frame and never otherwise.
REQ-018 o_Rx_Byte SHALL update only when o_Rx_DV asserts and SHALL hold its value until the next accepted frame.
REQ-019 Counter SHALL be 7 bits wide; it SHALL never exceed CLKS_PER_BIT-1.
REQ-020 A line held low through IDLE after CLEANUP SHALL be treated as a new start bit (back-to-back frames with one stop bit accepted).
REQ-021 i_Rx_Serial changes between sample points SHALL have no effect on o_Rx_Byte.

Reset
REQ-022 On i_Reset high at a clock edge: state IDLE, counter 0, index 0, o_Rx_DV 0, o_Rx_Byte 8'h00, o_Rx_Active 0, o_Rx_Frame_Err 0, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame without asserting o_Rx_DV; reception resumes on the next falling edge after reset releases.
REQ-024 Reset SHALL take priority over every state transition.

Configuration
REQ-025 Macro UART_RX_FRAME_ERR_EN defined: o_Rx_Frame_Err exists; a stop bit sampled 0 SHALL pulse o_Rx_Frame_Err for one cycle in place of o_Rx_DV, o_Rx_Byte unchanged; stop bit 1 behaves per REQ-015.
REQ-026 Macro undefined: o_Rx_Frame_Err port absent; stop-bit value ignored; o_Rx_DV pulses and o_Rx_Byte updates for every completed frame.

Verification
REQ-027 CLKS_PER_BIT=87, frame 0xA5 at 87 clks/bit -> single o_Rx_DV pulse, o_Rx_Byte=8'hA5, o_Rx_Active high from start detect to stop sample.
REQ-028 Line low 20 clocks then high -> no o_Rx_DV, state back to IDLE, o_Rx_Active low within 45 cycles.
REQ-029 Back-to-back frames 0x00 then 0xFF, one stop bit each -> two o_Rx_DV pulses, bytes 8'h00 then 8'hFF.
REQ-030 i_Reset pulsed during data bit 4 of 0x3C, then full frame 0x81 -> no pulse for aborted frame, one pulse with 8'h81.
REQ-031 With UART_RX_FRAME_ERR_EN, frame 0x55 with stop bit 0 -> o_Rx_Frame_Err pulse, no o_Rx_DV, o_Rx_Byte unchanged; without macro -> o_Rx_DV pulse, o_Rx_Byte=8'h55.
REQ-032 CLKS_PER_BIT=4, frame 0x96 -> o_Rx_Byte=8'h96, one o_Rx_DV pulse.
